// File: rtl/dm_pkg.sv
// Shared encodings for the data memory: store/load mode codes, sweep FSM states
// and the store-side alignment / byte-enable helpers.
package dm_pkg;

  localparam logic [1:0] ST_SW  = 2'd0;
  localparam logic [1:0] ST_SH  = 2'd1;
  localparam logic [1:0] ST_SB  = 2'd2;
  localparam logic [1:0] ST_RSV = 2'd3;

  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LHU = 3'd2;
  localparam logic [2:0] LD_LB  = 3'd3;
  localparam logic [2:0] LD_LBU = 3'd4;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  function automatic logic st_misalign(input logic [1:0] mode, input logic [1:0] a);
    case (mode)
      ST_SW:   return a != 2'b00;
      ST_SH:   return a[0];
      default: return 1'b0;
    endcase
  endfunction

  // Byte enables for a store; the reserved mode writes no lanes.
  function automatic logic [3:0] st_be(input logic [1:0] mode, input logic [1:0] a);
    case (mode)
      ST_SW:   return 4'hf;
      ST_SH:   return a[1] ? 4'hc : 4'h3;
      ST_SB:   return 4'b0001 << a;
      default: return 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/dm_ld_ext.sv
// Load extractor: picks the addressed half/byte out of a memory word, sign- or
// zero-extends it, and flags misaligned loads (which then return 0).
module dm_ld_ext
  import dm_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  a,
  input  logic [2:0]  ld_mode,
  output logic [31:0] data,
  output logic        misalign
);

  logic [15:0] half;
  logic [7:0]  byte_v;

  always_comb begin
    half   = a[1] ? word[31:16] : word[15:0];
    byte_v = word[7:0];
    case (a)
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      2'd3:    byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase

    data     = word;
    misalign = 1'b0;
    case (ld_mode)
      LD_LH:  begin misalign = a[0]; data = {{16{half[15]}}, half}; end
      LD_LHU: begin misalign = a[0]; data = {16'h0, half}; end
      LD_LB:  data = {{24{byte_v[7]}}, byte_v};
      LD_LBU: data = {24'h0, byte_v};
      default: begin misalign = a != 2'b00; data = word; end
    endcase
    if (misalign) data = '0;
  end

endmodule

// File: rtl/dm_ext.sv
// Data memory with sub-word stores, extending loads, misalignment detection and
// a post-reset clear sweep that zeroes one word per clock.
module dm_ext
  import dm_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter bit LOG_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  st_mode,
  input  logic [2:0]  ld_mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        addr_err
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  state_t        state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;

  logic [AW-1:0] idx;
  logic [31:0]   rd_word, ld_data, wlane, merged;
  logic [3:0]    be;
  logic          ld_mis, st_mis, wr_en;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    if (state_q == S_CLEAR) begin
      clr_idx_d = clr_idx_q + 1'b1;
      if (clr_idx_q == AW'(DEPTH - 1)) state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  assign busy = (state_q == S_CLEAR);

  assign idx     = addr[AW+1:2];
  assign rd_word = mem[idx];

  dm_ld_ext u_ld_ext (
    .word     (rd_word),
    .a        (addr[1:0]),
    .ld_mode  (ld_mode),
    .data     (ld_data),
    .misalign (ld_mis)
  );

  // Store side: replicate the payload across lanes, then merge by byte enable.
  always_comb begin
    st_mis = st_misalign(st_mode, addr[1:0]);
    be     = st_be(st_mode, addr[1:0]);
    case (st_mode)
      ST_SH:   wlane = {2{wdata[15:0]}};
      ST_SB:   wlane = {4{wdata[7:0]}};
      default: wlane = wdata;
    endcase
    for (int i = 0; i < 4; i++)
      merged[i*8 +: 8] = be[i] ? wlane[i*8 +: 8] : rd_word[i*8 +: 8];
    wr_en = !busy && we && !st_mis && (st_mode != ST_RSV);
  end

  assign addr_err = !busy && (we ? st_mis : ld_mis);
  assign rdata    = busy ? 32'h0 : ld_data;

  // No reset on the array itself; the sweep owns the write port while busy.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[clr_idx_q] <= '0;
    end else if (wr_en) begin
      mem[idx] <= merged;
      if (LOG_EN) $display("@%h: *%h <= %h", pc, {addr[31:2], 2'b00}, merged);
    end
  end

endmodule
